// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through a combinational instruction memory
// and hands each word to decode through a one-entry valid/ready slot.
module fetch_sequencer #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 32,
  parameter int                MEM_DEPTH = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              slot_free;
  logic              handoff;
  logic              redirect_oob;

  assign imem_addr    = pc;
  assign slot_free    = !out_valid || out_ready;
  assign handoff      = out_valid && out_ready;
  assign redirect_oob = redirect_addr > LAST_PC;

  // NOTE: every register here updates with <= so all of them sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      // Acceptance counts even when a redirect flushes the slot in the same cycle.
      if (handoff && fetch_count != 16'hFFFF)
        fetch_count <= fetch_count + 16'd1;

      unique case (state)
        IDLE: begin
          if (start)
            state <= FETCH;
        end

        FETCH, DRAIN: begin
          if (redirect_valid) begin
            out_valid <= 1'b0;
            if (redirect_oob) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc    <= redirect_addr;
              state <= FETCH;
            end
          end else if (state == FETCH) begin
            if (slot_free) begin
              out_instr <= imem_instr;
              out_pc    <= pc;
              out_valid <= 1'b1;
              pc        <= pc + ADDR_W'(1);
              if (pc == LAST_PC)
                state <= DRAIN;
            end
          end else if (slot_free) begin
            // Last word has left the slot; nothing more to fetch.
            out_valid <= 1'b0;
            state     <= HALT;
            halted    <= 1'b1;
          end
        end

        HALT: begin
          out_valid <= 1'b0;
          if (start) begin
            pc     <= RESET_PC;
            state  <= FETCH;
            halted <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
